// File: rtl/dualshock_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dualshock_poll_sequencer
// Purpose  : Runs one digital-mode 0x01/0x42 poll of a DualShock pad for each
//            poll request. It drives the pad bus, shifts in the reply and
//            validates the ID. It then publishes active-high button state in
//            DualShock order and in the packed NES order.
// Ports    : clk_p    - pixel clock, all logic on rising edge
//            reset    - asynchronous, active-high
//            poll_req - single-cycle poll request pulse
//            ps_miso  - pad data out (pulled up)
//            ps_clk   - pad clock, idle high
//            ps_sel   - pad attention, active-low
//            ps_mosi  - pad command data, LSB first
//            busy     - poll in progress (acceptance until valid)
//            valid    - one-cycle pulse at poll completion
//            link_ok  - last poll returned a recognised ID
//            buttons  - {~byte4, ~byte3}, active-high
//            nes_btn  - {R, L, D, U, START, SELECT, B, A}
// Revision : 1.0 - initial release
// ============================================================================
module dualshock_poll_sequencer #(
  parameter int HALF_BIT  = 50,
  parameter int NUM_BYTES = 5,
  parameter int GAP_BITS  = 1,
  parameter int MAX_FAILS = 3
) (
  input  logic        clk_p,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        ps_miso,
  output logic        ps_clk,
  output logic        ps_sel,
  output logic        ps_mosi,
  output logic        busy,
  output logic        valid,
  output logic        link_ok,
  output logic [15:0] buttons,
  output logic [7:0]  nes_btn
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_BIT_LO = 3'd2;
  localparam logic [2:0] S_BIT_HI = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  localparam int FULL_CYC = 2 * HALF_BIT;
  localparam int GAP_CYC  = (GAP_BITS > 0) ? GAP_BITS * FULL_CYC : 1;
  localparam int CNT_MAX  = (GAP_CYC > FULL_CYC) ? GAP_CYC : FULL_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BYTE_W   = $clog2(NUM_BYTES);
  localparam int FAIL_W   = $clog2(MAX_FAILS + 1);

  localparam logic [CNT_W-1:0]  HALF_END  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_END  = CNT_W'(FULL_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_END   = CNT_W'(GAP_CYC - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT  = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [BYTE_W-1:0] byte_idx;
  logic [2:0]        bit_idx;
  logic              pending;
  logic [FAIL_W-1:0] fail_cnt;
  logic              miso_meta;
  logic              miso_sync;
  logic [7:0]        rx_sh;
  logic [7:0]        rx_id;
  logic [7:0]        rx_sig;
  logic [7:0]        rx_b3;
  logic [7:0]        rx_b4;
  logic              id_good;
  logic [15:0]       new_buttons;

  // Command bytes: 0x01 (start), 0x42 (read data), then zeros.
  function automatic logic tx_bit(input logic [BYTE_W-1:0] b, input logic [2:0] i);
    logic [7:0] v;
    v = 8'h00;
    if (b == BYTE_W'(0)) v = 8'h01;
    else if (b == BYTE_W'(1)) v = 8'h42;
    return v[i];
  endfunction

  function automatic logic [7:0] nes_of(input logic [15:0] b);
    return {b[5], b[7], b[6], b[4], b[3], b[0], b[14], b[13]};
  endfunction

  assign id_good     = ((rx_id == 8'h41) || (rx_id == 8'h73)) && (rx_sig == 8'h5A);
  assign new_buttons = {~rx_b4, ~rx_b3};

  always_ff @(posedge clk_p or posedge reset) begin
    if (reset) begin
      miso_meta <= 1'b1;
      miso_sync <= 1'b1;
    end else begin
      miso_meta <= ps_miso;
      miso_sync <= miso_meta;
    end
  end

  always_ff @(posedge clk_p or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      pending  <= 1'b0;
      fail_cnt <= '0;
      ps_clk   <= 1'b1;
      ps_sel   <= 1'b1;
      ps_mosi  <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
      link_ok  <= 1'b0;
      buttons  <= '0;
      nes_btn  <= '0;
      rx_sh    <= 8'hFF;
      rx_id    <= 8'hFF;
      rx_sig   <= 8'hFF;
      rx_b3    <= 8'hFF;
      rx_b4    <= 8'hFF;
    end else begin
      valid <= 1'b0;
      // One-deep request memory; also catches a request on the final edge.
      if (poll_req && (state != S_IDLE)) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (poll_req || pending) begin
            state    <= S_SETUP;
            ps_sel   <= 1'b0;
            busy     <= 1'b1;
            pending  <= 1'b0;
            byte_idx <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
          end
        end

        S_SETUP: begin
          if (cnt == FULL_END) begin
            state   <= S_BIT_LO;
            ps_clk  <= 1'b0;
            ps_mosi <= tx_bit(byte_idx, bit_idx);
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BIT_LO: begin
          if (cnt == HALF_END) begin
            state  <= S_BIT_HI;
            ps_clk <= 1'b1;
            rx_sh  <= {miso_sync, rx_sh[7:1]};
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BIT_HI: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              state   <= S_BIT_LO;
              ps_clk  <= 1'b0;
              ps_mosi <= tx_bit(byte_idx, bit_idx + 3'd1);
            end else begin
              // Byte complete: keep the ones the result depends on.
              if (byte_idx == BYTE_W'(1)) rx_id  <= rx_sh;
              if (byte_idx == BYTE_W'(2)) rx_sig <= rx_sh;
              if (byte_idx == BYTE_W'(3)) rx_b3  <= rx_sh;
              if (byte_idx == BYTE_W'(4)) rx_b4  <= rx_sh;
              if (byte_idx != LAST_BYTE) begin
                byte_idx <= byte_idx + 1'b1;
                bit_idx  <= '0;
                state    <= S_GAP;
                ps_mosi  <= 1'b1;
              end else begin
                state <= S_HOLD;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if ((GAP_BITS == 0) || (cnt == GAP_END)) begin
            state   <= S_BIT_LO;
            ps_clk  <= 1'b0;
            ps_mosi <= tx_bit(byte_idx, bit_idx);
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt == FULL_END) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ps_sel  <= 1'b1;
            ps_mosi <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b1;
            if (id_good) begin
              buttons  <= new_buttons;
              nes_btn  <= nes_of(new_buttons);
              link_ok  <= 1'b1;
              fail_cnt <= '0;
            end else begin
              link_ok <= 1'b0;
              if (fail_cnt < FAIL_SAT) fail_cnt <= fail_cnt + 1'b1;
              // This bad poll brings the count to the limit: release all.
              if (fail_cnt >= FAIL_LAST) begin
                buttons <= '0;
                nes_btn <= '0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          ps_sel <= 1'b1;
          ps_clk <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dualshock_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dualshock_poll_sequencer
// Purpose  : Self-checking bench for dualshock_poll_sequencer with a pad model
//            and a queue of expected poll results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dualshock_poll_sequencer;

  localparam int LAT = 4601;

  logic        clk_p = 1'b0;
  logic        reset = 1'b1;
  logic        poll_req = 1'b0;
  logic        ps_miso = 1'b1;
  logic        ps_clk;
  logic        ps_sel;
  logic        ps_mosi;
  logic        busy;
  logic        valid;
  logic        link_ok;
  logic [15:0] buttons;
  logic [7:0]  nes_btn;

  dualshock_poll_sequencer dut (
    .clk_p    (clk_p),
    .reset    (reset),
    .poll_req (poll_req),
    .ps_miso  (ps_miso),
    .ps_clk   (ps_clk),
    .ps_sel   (ps_sel),
    .ps_mosi  (ps_mosi),
    .busy     (busy),
    .valid    (valid),
    .link_ok  (link_ok),
    .buttons  (buttons),
    .nes_btn  (nes_btn)
  );

  always #5 clk_p = ~clk_p;

  int cyc = 0;
  always @(posedge clk_p) cyc++;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [15:0] btn;
    logic [7:0]  nes;
    logic        link;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Pad model: drives reply on ps_clk fall, captures command on ps_clk rise.
  logic [71:0] pad_reply = '1;
  logic [71:0] mosi_bits = '0;
  logic        pad_float = 1'b0;
  int          pbit = 0;

  always @(negedge ps_sel) pbit = 0;
  always @(posedge ps_sel) ps_miso = 1'b1;
  always @(negedge ps_clk) begin
    if (ps_sel === 1'b0 && pbit < 72) ps_miso = pad_float ? 1'b1 : pad_reply[pbit];
  end
  always @(posedge ps_clk) begin
    if (ps_sel === 1'b0 && pbit < 72) begin
      mosi_bits[pbit] = ps_mosi;
      pbit++;
    end
  end

  // Output monitor: scoreboard compare on valid, bus timing statistics.
  int valid_cnt = 0;
  int sel_fall_cyc = 0;
  int sel_run = 0, clk_run = 0, falls = 0, bad_lo = 0;
  int last_sel_len = 0, last_falls = 0, last_bad = 0;
  logic prev_sel = 1'b1, prev_clk = 1'b1;

  always @(negedge clk_p) begin
    exp_t e;
    if (valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("latency_cycle", cyc, e.cyc);
        check_eq("link_ok", link_ok, e.link);
        check_eq("buttons", buttons, e.btn);
        check_eq("nes_btn", nes_btn, e.nes);
      end
    end
    if (!ps_sel && prev_sel) begin
      sel_fall_cyc = cyc;
      sel_run = 0; clk_run = 0; falls = 0; bad_lo = 0;
    end
    if (!ps_sel) begin
      sel_run++;
      if (!ps_clk) begin
        clk_run++;
        if (prev_clk) falls++;
      end else if (!prev_clk) begin
        if (clk_run != 50) bad_lo++;
        clk_run = 0;
      end
    end else if (!prev_sel) begin
      last_sel_len = sel_run;
      last_falls   = falls;
      last_bad     = bad_lo;
    end
    prev_sel = ps_sel;
    prev_clk = ps_clk;
  end

  task automatic set_reply(input logic [7:0] b0, b1, b2, b3, b4);
    pad_reply = {32'hFFFF_FFFF, b4, b3, b2, b1, b0};
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_p); #1;
    end
  endtask

  // One-cycle request pulse launched just after the current edge.
  task automatic pulse_req();
    poll_req = 1'b1;
    @(posedge clk_p); #1;
    poll_req = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] b, input logic [7:0] n, input logic l, input int c);
    exp_t e;
    e.btn = b; e.nes = n; e.link = l; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_p); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_poll(input logic [15:0] b, input logic [7:0] n, input logic l);
    int c0;
    @(posedge clk_p); #1;
    c0 = cyc;
    push_exp(b, n, l, c0 + LAT);
    pulse_req();
    wait_drain(LAT + 200);
  endtask

  initial begin
    int c0;
    int vc0;

    // Reset state
    repeat (3) @(posedge clk_p);
    #1;
    check_eq("rst_ps_sel", ps_sel, 1'b1);
    check_eq("rst_ps_clk", ps_clk, 1'b1);
    check_eq("rst_ps_mosi", ps_mosi, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_link_ok", link_ok, 1'b0);
    check_eq("rst_buttons", buttons, 16'h0);
    check_eq("rst_nes_btn", nes_btn, 8'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk_p);
    #1;

    // Digital ID reply, SELECT + X; also bus timing
    set_reply(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hBF);
    c0 = cyc;
    push_exp(16'h4001, 8'h06, 1'b1, c0 + LAT);
    pulse_req();
    repeat (10) @(posedge clk_p);
    #1;
    check_eq("busy_during_poll", busy, 1'b1);
    wait_drain(LAT + 200);
    repeat (2) @(posedge clk_p);
    #1;
    check_eq("busy_after_poll", busy, 1'b0);
    check_eq("sel_low_cycles", last_sel_len, 4600);
    check_eq("clk_falls", last_falls, 40);
    check_eq("clk_low_bad_runs", last_bad, 0);
    check_eq("mosi_byte0", mosi_bits[7:0], 8'h01);
    check_eq("mosi_byte1", mosi_bits[15:8], 8'h42);
    check_eq("mosi_bytes2_4", mosi_bits[39:16], 24'h0);
    check_eq("mosi_idle", ps_mosi, 1'b1);

    // Analog ID reply, Up + O
    set_reply(8'hFF, 8'h73, 8'h5A, 8'hEF, 8'hDF);
    do_poll(16'h2010, 8'h11, 1'b1);

    // Pad released: held buttons for two polls, released on the third
    pad_float = 1'b1;
    do_poll(16'h2010, 8'h11, 1'b0);
    do_poll(16'h2010, 8'h11, 1'b0);
    do_poll(16'h0000, 8'h00, 1'b0);
    pad_float = 1'b0;

    // Good poll restores link and clears the fail count
    set_reply(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hBF);
    do_poll(16'h4001, 8'h06, 1'b1);

    // Requests at 0, 100, 200: one pending, one dropped
    set_reply(8'hFF, 8'h73, 8'h5A, 8'hEF, 8'hDF);
    @(posedge clk_p); #1;
    c0 = cyc;
    vc0 = valid_cnt;
    push_exp(16'h2010, 8'h11, 1'b1, c0 + LAT);
    push_exp(16'h2010, 8'h11, 1'b1, c0 + 2 * LAT);
    pulse_req();
    wait_until(c0 + 100);
    pulse_req();
    wait_until(c0 + 200);
    pulse_req();
    wait_drain(2 * LAT + 400);
    check_eq("second_sel_fall", sel_fall_cyc, c0 + LAT + 1);
    repeat (5000) @(posedge clk_p);
    #1;
    check_eq("transaction_count", valid_cnt - vc0, 2);

    // Reset mid-transaction
    @(posedge clk_p); #1;
    c0 = cyc;
    vc0 = valid_cnt;
    pulse_req();
    wait_until(c0 + 2000);
    reset = 1'b1;
    #1;
    check_eq("abort_ps_sel", ps_sel, 1'b1);
    check_eq("abort_ps_clk", ps_clk, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_link_ok", link_ok, 1'b0);
    check_eq("abort_buttons", buttons, 16'h0);
    repeat (3) @(posedge clk_p);
    #1;
    reset = 1'b0;
    repeat (3000) @(posedge clk_p);
    #1;
    check_eq("abort_no_valid", valid_cnt - vc0, 0);
    set_reply(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hBF);
    do_poll(16'h4001, 8'h06, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dualshock_poll_sequencer.md
Name: dualshock_poll_sequencer

Overview:
Self-contained poll engine for the DualShock pad on the Tang Nano 20K, running on the 25.2 MHz pixel clock. It replaces the free-running 250 kHz divider plus external controller with one block. On each poll request it runs one digital-mode 0x01/0x42 transaction: it drives ps_clk/ps_sel/ps_mosi, shifts in the reply and checks the ID bytes. It then publishes debounced-free active-high button state in both DualShock order and the packed NES order used by the game top level.

Parameters:
HALF_BIT, 50, clk_p cycles per ps_clk half-period (25.2 MHz / 100 = 252 kHz)
NUM_BYTES, 5, bytes per transaction (min 5, max 9)
GAP_BITS, 1, idle bit-times (2*HALF_BIT cycles each) between bytes, ps_clk high
MAX_FAILS, 3, consecutive bad-ID polls before buttons are forced released

Ports:
clk_p  in  1  pixel clock, 25.2 MHz, all logic on rising edge
reset  in  1  asynchronous, active-high
poll_req  in  1  single-cycle pulse starting a poll (top level ties to vsync rising edge)
ps_miso  in  1  pad data out (open-drain, pulled up externally)
ps_clk  out  1  pad clock, idle high
ps_sel  out  1  pad attention, active-low
ps_mosi  out  1  pad command data, LSB first
busy  out  1  high from poll acceptance until valid
valid  out  1  one-cycle pulse when a poll completes (good or bad)
link_ok  out  1  high while most recent poll had ID 0x41 or 0x73 and byte2 = 0x5A
buttons  out  16  active-high: [7:0] = ~rx byte3 (bit7 L, 6 D, 5 R, 4 U, 3 St, 2 R3, 1 L3, 0 Se); [15:8] = ~rx byte4 (15 Sq, 14 X, 13 O, 12 Tri, 11 R1, 10 L1, 9 R2, 8 L2)
nes_btn  out  8  {R, L, D, U, START, SELECT, B=X, A=O} taken from buttons

Behaviour:
- Reset (async): ps_sel=1, ps_clk=1, ps_mosi=1, busy=0, valid=0, link_ok=0, buttons=0, nes_btn=0, fail count=0, pending=0, state IDLE.
- ps_miso passes through a 2-FF synchronizer; all sampling uses the synchronized value.
- States: IDLE -> SETUP -> BIT_LO -> BIT_HI -> (GAP | HOLD) -> IDLE.
- IDLE: on poll_req or pending, go to SETUP, ps_sel<=0, busy<=1, clear pending, byte_idx=0, bit_idx=0.
- SETUP: wait 2*HALF_BIT cycles with ps_clk=1, then BIT_LO.
- BIT_LO: on entry ps_clk<=0 and ps_mosi<=tx[byte_idx][bit_idx]; hold HALF_BIT cycles, then BIT_HI.
- BIT_HI: on entry ps_clk<=1 and the synchronized miso is shifted into rx[byte_idx] bit bit_idx (LSB first); hold HALF_BIT cycles.
  - If bit_idx<7: bit_idx++ and go to BIT_LO.
  - Else if byte_idx<NUM_BYTES-1: byte_idx++, bit_idx=0, go to GAP (ps_mosi<=1).
  - Else go to HOLD.
- GAP: GAP_BITS*2*HALF_BIT cycles with ps_clk=1, then BIT_LO. The ACK line is not monitored.
- HOLD: 2*HALF_BIT cycles, then ps_sel<=1, ps_mosi<=1, busy<=0, valid<=1 in the same edge, and the result is evaluated.
- tx bytes: byte0=0x01, byte1=0x42, all others 0x00.
- Result on a good ID: buttons<={~rx4,~rx3}, link_ok<=1, fail count<=0.
- Result on a bad ID: buttons hold their value and link_ok<=0. The fail count increments, saturating at MAX_FAILS. When the count reaches MAX_FAILS, buttons<=0.
- nes_btn is registered together with buttons, i.e. updated in the same cycle as valid.
- Latency from the poll_req edge to the valid edge: T = 1 + 2H + 16H*NB + 2H*GAP*(NB-1) + 2H. With defaults this is 4601 cycles.
- poll_req while busy sets pending (one-deep; further requests are dropped). A poll_req in the same cycle as valid also sets pending. The next poll starts on the cycle after valid.
- A pad released mid-transaction (miso floats high) reads all 0xFF, which is a bad ID.
- Reset mid-transaction aborts immediately with outputs at their reset values. No partial results are published.

Test Plan:
- Pad model replies FF 41 5A FE BF; single poll_req -> valid exactly 4601 cycles later, link_ok=1, buttons=16'h4001, nes_btn=8'h06 (SELECT+B).
- Same poll, checking bus timing -> ps_sel low 4600 cycles; 40 ps_clk falls of 50 cycles each; mosi bits 0x01,0x42 LSB first; miso captured on ps_clk rise.
- Reply FF 73 5A EF DF (analog ID, Up+O) -> link_ok=1, buttons=16'h2010, nes_btn=8'h11.
- miso held high for 3 polls after a good poll with buttons=16'h2010 -> polls 1-2 keep 16'h2010 with link_ok=0; poll 3 sets buttons=0, nes_btn=0.
- poll_req pulsed at cycles 0, 100 and 200 -> exactly two transactions; the second ps_sel falls the cycle after the first valid.
- reset asserted at cycle 2000 of a poll -> ps_sel=1, ps_clk=1, busy=0 immediately; no valid pulse; after release, the next poll_req performs a normal 4601-cycle poll.
